// File: rtl/fp_add_align_sum_if.sv
// Operand/result handshake bundle for the FP adder pre-normalisation stage.
// The master side presents operands and consumes results; the slave side is the adder.
interface fp_add_align_sum_if #(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8,
    parameter int LZC_W = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   op_a;
    logic [EXP_W+MAN_W:0]   op_b;
    logic                   op_sub;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sign;
    logic [MAN_W:0]         result;
    logic [EXP_W-1:0]       exponent;
    logic                   carry;
    logic [LZC_W-1:0]       num_lead_zero;
    logic                   zero;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, sign, result, exponent, carry, num_lead_zero, zero
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, sign, result, exponent, carry, num_lead_zero, zero
    );
endinterface

// File: rtl/fp_add_align_sum.sv
// Two-stage elastic pre-normalisation for the binary32 adder: S1 unpacks, orders and
// aligns the operands, S2 adds/subtracts the mantissas and counts leading zeros.
module fp_add_align_sum #(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8,
    parameter int LZC_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    fp_add_align_sum_if.slave       bus
);
    localparam int SIG_W = MAN_W + 1;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic                 v1_q, v1_d, v2_q, v2_d;
    logic                 s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic [EXP_W-1:0]     s1_exp_q, s1_exp_d;
    logic [SIG_W-1:0]     s1_man_l_q, s1_man_l_d, s1_man_s_q, s1_man_s_d;

    logic                 sign_q, sign_d, carry_q, carry_d, zero_q, zero_d;
    logic [SIG_W-1:0]     result_q, result_d;
    logic [EXP_W-1:0]     exponent_q, exponent_d;
    logic [LZC_W-1:0]     num_lead_zero_q, num_lead_zero_d;

    logic                 in_ready, advance, load;

    logic [EXP_W-1:0]     exp_a_raw, exp_b_raw, exp_a, exp_b, exp_l, exp_s, shift;
    logic [SIG_W-1:0]     man_a, man_b, man_l, man_s, man_s_aligned;
    logic                 sign_b_eff, sign_l, a_is_l;

    logic [SIG_W:0]       sum_full;
    logic [SIG_W-1:0]     sum_res;
    logic                 sum_carry, sum_zero, lz_found;
    logic [LZC_W-1:0]     lz_count;

    // S1: unpack, order by magnitude (A wins ties), align the smaller mantissa
    always_comb begin
        exp_a_raw  = bus.op_a[W-2 -: EXP_W];
        exp_b_raw  = bus.op_b[W-2 -: EXP_W];
        exp_a      = (exp_a_raw == '0) ? EXP_W'(1) : exp_a_raw;
        exp_b      = (exp_b_raw == '0) ? EXP_W'(1) : exp_b_raw;
        man_a      = {exp_a_raw != '0, bus.op_a[MAN_W-1:0]};
        man_b      = {exp_b_raw != '0, bus.op_b[MAN_W-1:0]};
        sign_b_eff = bus.op_b[W-1] ^ bus.op_sub;
        a_is_l     = {exp_a, man_a} >= {exp_b, man_b};

        if (a_is_l) begin
            sign_l = bus.op_a[W-1];
            exp_l  = exp_a;
            exp_s  = exp_b;
            man_l  = man_a;
            man_s  = man_b;
        end else begin
            sign_l = sign_b_eff;
            exp_l  = exp_b;
            exp_s  = exp_a;
            man_l  = man_b;
            man_s  = man_a;
        end

        shift = exp_l - exp_s;
        if (shift >= EXP_W'(SIG_W)) begin
            man_s_aligned = '0;
        end else begin
            man_s_aligned = man_s >> shift;
        end
    end

    // S2: magnitude add/subtract; ordering guarantees the difference is non-negative
    always_comb begin
        if (s1_sub_q) begin
            sum_full = {1'b0, s1_man_l_q - s1_man_s_q};
        end else begin
            sum_full = {1'b0, s1_man_l_q} + {1'b0, s1_man_s_q};
        end
        sum_carry = sum_full[SIG_W];
        sum_res   = sum_full[SIG_W-1:0];
        sum_zero  = !sum_carry && (sum_res == '0);

        lz_count = '0;
        lz_found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum_res[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz_count = lz_count + LZC_W'(1);
                end
            end
        end
    end

    always_comb begin
        in_ready = !v1_q || !v2_q || bus.out_ready;
        advance  = !v2_q || bus.out_ready;
        load     = bus.in_valid && in_ready;

        s1_sign_d       = s1_sign_q;
        s1_sub_d        = s1_sub_q;
        s1_exp_d        = s1_exp_q;
        s1_man_l_d      = s1_man_l_q;
        s1_man_s_d      = s1_man_s_q;
        sign_d          = sign_q;
        result_d        = result_q;
        exponent_d      = exponent_q;
        carry_d         = carry_q;
        num_lead_zero_d = num_lead_zero_q;
        zero_d          = zero_q;

        v1_d = load || (v1_q && !advance);
        v2_d = advance ? v1_q : v2_q;

        if (load) begin
            s1_sign_d  = sign_l;
            s1_sub_d   = bus.op_a[W-1] ^ sign_b_eff;
            s1_exp_d   = exp_l;
            s1_man_l_d = man_l;
            s1_man_s_d = man_s_aligned;
        end

        // Output registers only change when a real item moves into S2
        if (advance && v1_q) begin
            sign_d          = sum_zero ? 1'b0 : s1_sign_q;
            result_d        = sum_res;
            exponent_d      = sum_zero ? '0 : s1_exp_q;
            carry_d         = sum_carry;
            num_lead_zero_d = (sum_carry || sum_zero) ? '0 : lz_count;
            zero_d          = sum_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q            <= 1'b0;
            v2_q            <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_sub_q        <= 1'b0;
            s1_exp_q        <= '0;
            s1_man_l_q      <= '0;
            s1_man_s_q      <= '0;
            sign_q          <= 1'b0;
            result_q        <= '0;
            exponent_q      <= '0;
            carry_q         <= 1'b0;
            num_lead_zero_q <= '0;
            zero_q          <= 1'b0;
        end else begin
            v1_q            <= v1_d;
            v2_q            <= v2_d;
            s1_sign_q       <= s1_sign_d;
            s1_sub_q        <= s1_sub_d;
            s1_exp_q        <= s1_exp_d;
            s1_man_l_q      <= s1_man_l_d;
            s1_man_s_q      <= s1_man_s_d;
            sign_q          <= sign_d;
            result_q        <= result_d;
            exponent_q      <= exponent_d;
            carry_q         <= carry_d;
            num_lead_zero_q <= num_lead_zero_d;
            zero_q          <= zero_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = v2_q;
    assign bus.sign          = sign_q;
    assign bus.result        = result_q;
    assign bus.exponent      = exponent_q;
    assign bus.carry         = carry_q;
    assign bus.num_lead_zero = num_lead_zero_q;
    assign bus.zero          = zero_q;
endmodule

// File: doc/fp_add_align_sum.md
Name: fp_add_align_sum

Overview:
- Pre-normalisation stage of the single-precision FP adder in the convolution accelerator's accumulate path.
- Accepts two IEEE-754 binary32 operands and an add/sub select, then unpacks, orders by magnitude, aligns and adds/subtracts the mantissas, and counts leading zeros.
- Outputs {result, exponent, carry, lead-zero count} drive the normalisation stage directly.
- Two-stage elastic pipeline with valid/ready handshake on both sides.

Parameters:
- MAN_W, 23, stored mantissa width (hidden bit adds 1).
- EXP_W, 8, exponent width.
- LZC_W, 5, leading-zero count width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept an operand pair this cycle.
- op_a  input  32  operand A, binary32.
- op_b  input  32  operand B, binary32.
- op_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- sign  output  1  result sign.
- result  output  24  magnitude sum, excluding carry bit.
- exponent  output  8  exponent of the larger operand.
- carry  output  1  bit 24 of the magnitude sum.
- num_lead_zero  output  5  leading zeros of result; 0 when carry=1 or zero=1.
- zero  output  1  exact-zero result.

Behaviour:
- Reset (async, active-high): both stage-valid flags clear, so out_valid=0. sign, result, exponent, carry, num_lead_zero and zero all reset to 0. in_ready=1 once rst deasserts.
- Handshake:
  - A transfer occurs on a rising edge with valid&ready.
  - in_ready = !v1 | !v2 | out_ready (combinational).
  - S1 advances into S2 when !v2 | out_ready.
  - Outputs hold stable while out_valid & !out_ready.
  - No bubbles under continuous flow: one result per cycle.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Order is preserved.
- S1 (unpack/swap/align):
  - Mantissa = {hidden, frac}, with hidden = (exp != 0).
  - Effective exponent = 1 when exp == 0 (denormal).
  - Effective B sign = sb ^ op_sub.
  - Swap so that L = larger of {exp, man}. On a tie, A is L.
  - d = eL - eS. Aligned S = manS >> d; if d >= 24 it is 0. Shifted-out bits are discarded (no guard/sticky).
  - S1 registers: sign(L), eL, manL, aligned S, eff_sub = sa ^ sb_eff.
- S2 (sum/LZC):
  - eff_sub=0: {carry, result} = manL + S.
  - eff_sub=1: result = manL - S, carry = 0; never negative because of the ordering.
  - num_lead_zero = count of leading zeros in result[23:0], range 0..23, when carry=0 and result != 0.
  - Zero case (result==0, carry==0): zero=1, sign=0, exponent=0, num_lead_zero=0.
  - Otherwise exponent = eL.
- Special values: exp=255 (Inf/NaN) is processed arithmetically as a normal number; flagging is out of scope for this block.
- Simultaneous events:
  - S2 unload and S1 advance in the same cycle is allowed.
  - S1 load and S1 advance in the same cycle is allowed.
  - Full pipeline with out_ready=0 gives in_ready=0.
- Reset mid-operation: in-flight data is discarded immediately; no output transfer is produced for it.

Test Plan:
- 1.0+1.0: op_a=op_b=0x3F800000, op_sub=0 → 2 cycles later out_valid=1, carry=1, result=0x000000, exponent=0x7F, sign=0, num_lead_zero=0, zero=0.
- 1.5-1.0: 0x3FC00000, 0x3F800000, op_sub=1 → result=0x400000, carry=0, exponent=0x7F, num_lead_zero=1, sign=0.
- 2.0-3.0: 0x40000000, 0x40400000, op_sub=1 → swap; result=0x400000, exponent=0x80, sign=1, num_lead_zero=1.
- Large shift: 1.0 + 2^-30 (0x3F800000, 0x30800000; d=30) → result=0x800000, carry=0, exponent=0x7F, num_lead_zero=0.
- Cancellation: 0x41200000 - 0x41200000 → zero=1, result=0, exponent=0, sign=0, num_lead_zero=0.
- Backpressure, then reset:
  - Hold out_ready=0 and present 3 back-to-back valid pairs → first two accepted, in_ready=0 on the third, outputs stable.
  - Raise out_ready → results emerge in order, one per cycle.
  - Assert rst with 2 items in flight → out_valid=0 asynchronously; no stale output afterwards.
